vga_line_fetcher: RTL and testbench
===================================

// Module: vga_line_fetcher
// PURPOSE
//  Avalon-MM read master that prefetches one row of the sand-cell grid from SDRAM into a
//  ping-pong line buffer. vga_render reads cell types from it by column, one row ahead of
//  display, so SDRAM latency never stalls the pixel pipeline. Sits between SDRAM and vga_render.
// PARAMETERS
//  CELL_BITS      2    bits per cell (00 empty, 01 sand, 10 water, 11 wall)
//  CELLS_PER_WORD 16   cells packed per 32-bit word, cell 0 in bits [1:0]
//  WORDS_PER_ROW  10   words per grid row (160 cells)
//  MAX_PENDING    4    max outstanding reads (issued, readdatavalid not yet seen)
// PORTS
//  clock             in   1   system clock (50 MHz)
//  reset             in   1   asynchronous, active-high reset
//  mem_address       out  24  word address of current read
//  mem_read          out  1   read request; held until accepted
//  mem_waitrequest   in   1   slave stall; read accepted on a cycle with mem_read=1, waitrequest=0
//  mem_readdata      in   32  returned word
//  mem_readdatavalid in   1   mem_readdata valid; returns arrive in issue order
//  frame_base        in   24  word address of row 0 of active screen buffer; sampled on line_req
//  line_req          in   1   1-cycle pulse: swap buffers, start fetching line_row
//  line_row          in   8   row to fetch (0..119); sampled with line_req
//  rd_col            in   8   display-side cell column (0..159)
//  rd_cell           out  2   cell type at rd_col in front buffer; 1-cycle registered latency
//  line_ready        out  1   back buffer fully fetched for last requested row
//  underrun          out  1   1-cycle pulse: line_req arrived before back buffer complete
// BEHAVIOUR
//  Reset (async): mem_read=0, mem_address=0, rd_cell=0, line_ready=0, underrun=0,
//   state=IDLE, pending=0, front_sel=0, front_valid=0. Buffer RAM contents are undefined.
//  FSM states: IDLE, ISSUE, DRAIN.
//   IDLE: on line_req: swap front_sel, front_valid<=line_ready, line_ready<=0,
//     base<=frame_base+line_row*WORDS_PER_ROW (24-bit, wraps), issue_idx<=0, ret_idx<=0 -> ISSUE.
//   ISSUE: mem_read=1 while issue_idx<WORDS_PER_ROW and pending<MAX_PENDING;
//     mem_address=base+issue_idx. Accept increments issue_idx and pending.
//     Each readdatavalid writes back[ret_idx]; ret_idx++ and pending--.
//     Accept and return in the same cycle leave pending unchanged.
//     ret_idx==WORDS_PER_ROW: line_ready<=1 -> IDLE.
//   line_req while in ISSUE: underrun pulses the next cycle, swap happens with front_valid<=0,
//     mem_read drops that cycle (no new issue), new row/base latched as pending_req -> DRAIN.
//   DRAIN: mem_read=0; returning data discarded (no buffer write), pending--.
//     pending==0: start latched request (as IDLE) -> ISSUE.
//     A further line_req in DRAIN overwrites pending_req and pulses underrun again.
//  mem_read/mem_address are registered. Both stay stable while waitrequest=1.
//   A request is never withdrawn before acceptance except on line_req abort.
//  Read side: word=rd_col/16, slot=rd_col%16; rd_cell <= front[word][2*slot+:2] next cycle.
//   rd_cell=00 if rd_col>=160 or front_valid=0.
//  Simultaneous: readdatavalid in the line_req cycle still writes the old back buffer
//   (pre-swap index), then counts toward DRAIN.
//  Reset mid-fetch: all state cleared. Later readdatavalid with pending=0 is ignored (no underflow).
// TESTING
//  1 Zero-wait slave, fixed 3-cycle latency, frame_base=0x000100, line_req row 2 ->
//    addresses 0x000114..0x00011D in order; line_ready after 10th return.
//  2 Second line_req after line_ready; word0=0x0000_00E4 ->
//    rd_col 0,1,2,3 give rd_cell 0,1,2,3, each 1 cycle after rd_col.
//  3 waitrequest held high 5 cycles on word 3 -> mem_read and address 0x...3 stable throughout;
//    no more than 4 outstanding ever.
//  4 line_req after 6 returns -> underrun pulse; mem_read=0 until all 4 outstanding drained;
//    new row fetched; rd_cell=0 for all columns.
//  5 rd_col=160 and 255 -> rd_cell=00. Cell 159 = bits [31:30] of word 9.
//  6 Assert reset with 3 reads outstanding, then deliver 3 stray readdatavalids ->
//    outputs at reset values; pending stays 0; line_ready stays 0.

Source files
------------

// File: rtl/vga_line_fetcher.sv
// Avalon-MM read master that prefetches one sand-grid row from SDRAM into a
// ping-pong line buffer. The display side reads the front bank by column while
// the back bank fills with the next row.
module vga_line_fetcher #(
  parameter int unsigned CellBits     = 2,
  parameter int unsigned CellsPerWord = 16,
  parameter int unsigned WordsPerRow  = 10,
  parameter int unsigned MaxPending   = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic [23:0]                      mem_address_o,
  output logic                             mem_read_o,
  input  logic                             mem_waitrequest_i,
  input  logic [CellBits*CellsPerWord-1:0] mem_readdata_i,
  input  logic                             mem_readdatavalid_i,
  input  logic [23:0]                      frame_base_i,
  input  logic                             line_req_i,
  input  logic [7:0]                       line_row_i,
  input  logic [7:0]                       rd_col_i,
  output logic [CellBits-1:0]              rd_cell_o,
  output logic                             line_ready_o,
  output logic                             underrun_o
);

  localparam int unsigned WordW    = CellBits * CellsPerWord;
  localparam int unsigned PendW    = $clog2(MaxPending + 1);
  localparam int unsigned IdxW     = $clog2(WordsPerRow + 1);
  localparam int unsigned MemDepth = 2 * WordsPerRow;
  localparam int unsigned MemAw    = $clog2(MemDepth);

  localparam logic [IdxW-1:0]  RowWords  = IdxW'(WordsPerRow);
  localparam logic [PendW-1:0] PendLimit = PendW'(MaxPending);
  localparam logic [7:0]       NumCols   = 8'(CellsPerWord * WordsPerRow);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e               state_q, state_d;
  logic [PendW-1:0]     pending_q, pending_d;
  logic                 front_sel_q, front_sel_d;
  logic                 front_valid_q, front_valid_d;
  logic                 line_ready_q, line_ready_d;
  logic                 underrun_q, underrun_d;
  logic [23:0]          base_q, base_d;
  logic [23:0]          pend_base_q, pend_base_d;
  logic [IdxW-1:0]      issue_idx_q, issue_idx_d;
  logic [IdxW-1:0]      ret_idx_q, ret_idx_d;
  logic                 mem_read_q, mem_read_d;
  logic [23:0]          mem_addr_q, mem_addr_d;
  logic [CellBits-1:0]  rd_cell_q, rd_cell_d;

  // Bank 0 holds words [0, WordsPerRow), bank 1 the next WordsPerRow words.
  logic [WordW-1:0]     line_mem_q [MemDepth];

  logic                 accept;
  logic                 ret_valid;
  logic [23:0]          req_base;
  logic                 wr_en;
  logic [MemAw-1:0]     wr_addr;

  logic [7:0]           rd_word;
  logic [7:0]           rd_slot;
  logic [MemAw-1:0]     rd_idx;
  logic [WordW-1:0]     rd_shift;

  // Handshake qualifiers; returns with nothing outstanding (after a reset) are dropped.
  always_comb begin
    accept    = mem_read_q & ~mem_waitrequest_i;
    ret_valid = mem_readdatavalid_i & (pending_q != '0);
    req_base  = frame_base_i + 24'(line_row_i) * 24'(WordsPerRow);
    wr_addr   = front_sel_q ? MemAw'(ret_idx_q) : MemAw'(ret_idx_q) + MemAw'(WordsPerRow);
  end

  // Fetch FSM next state plus the registered read request it drives.
  always_comb begin
    state_d       = state_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    line_ready_d  = line_ready_q;
    underrun_d    = 1'b0;
    base_d        = base_q;
    pend_base_d   = pend_base_q;
    ret_idx_d     = ret_idx_q;
    wr_en         = 1'b0;
    mem_read_d    = 1'b0;
    mem_addr_d    = mem_addr_q;
    // An accept on the abort cycle is still a real outstanding read.
    pending_d     = pending_q + PendW'(accept) - PendW'(ret_valid);
    issue_idx_d   = issue_idx_q + IdxW'(accept);

    unique case (state_q)
      StIdle: begin
        if (line_req_i) begin
          front_sel_d   = ~front_sel_q;
          front_valid_d = line_ready_q;
          line_ready_d  = 1'b0;
          base_d        = req_base;
          issue_idx_d   = '0;
          ret_idx_d     = '0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (ret_valid) begin
          // Uses the pre-swap bank even when line_req lands on this cycle.
          wr_en     = 1'b1;
          ret_idx_d = ret_idx_q + 1'b1;
        end
        if (line_req_i) begin
          underrun_d    = 1'b1;
          front_sel_d   = ~front_sel_q;
          front_valid_d = 1'b0;
          pend_base_d   = req_base;
          state_d       = StDrain;
        end else if (ret_idx_d == RowWords) begin
          line_ready_d = 1'b1;
          state_d      = StIdle;
        end
      end
      StDrain: begin
        if (line_req_i) begin
          underrun_d  = 1'b1;
          pend_base_d = req_base;
        end
        if (pending_d == '0) begin
          base_d      = line_req_i ? req_base : pend_base_q;
          issue_idx_d = '0;
          ret_idx_d   = '0;
          state_d     = StIssue;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StIssue) begin
      if (mem_read_q && mem_waitrequest_i) begin
        // Stalled request must stay put until the slave takes it.
        mem_read_d = 1'b1;
      end else if ((issue_idx_d < RowWords) && (pending_d < PendLimit)) begin
        mem_read_d = 1'b1;
        mem_addr_d = base_d + 24'(issue_idx_d);
      end
    end
  end

  // Display-side lookup into the front bank; out-of-range or invalid reads give empty.
  always_comb begin
    rd_word   = '0;
    rd_slot   = '0;
    rd_cell_d = '0;
    if (rd_col_i < NumCols) begin
      rd_word = rd_col_i / 8'(CellsPerWord);
      rd_slot = rd_col_i % 8'(CellsPerWord);
    end
    rd_idx   = front_sel_q ? MemAw'(rd_word) + MemAw'(WordsPerRow) : MemAw'(rd_word);
    rd_shift = line_mem_q[rd_idx] >> (32'(rd_slot) * CellBits);
    if (front_valid_q && (rd_col_i < NumCols)) begin
      rd_cell_d = rd_shift[CellBits-1:0];
    end
  end

  // Control and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      line_ready_q  <= 1'b0;
      underrun_q    <= 1'b0;
      base_q        <= '0;
      pend_base_q   <= '0;
      issue_idx_q   <= '0;
      ret_idx_q     <= '0;
      mem_read_q    <= 1'b0;
      mem_addr_q    <= '0;
      rd_cell_q     <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      line_ready_q  <= line_ready_d;
      underrun_q    <= underrun_d;
      base_q        <= base_d;
      pend_base_q   <= pend_base_d;
      issue_idx_q   <= issue_idx_d;
      ret_idx_q     <= ret_idx_d;
      mem_read_q    <= mem_read_d;
      mem_addr_q    <= mem_addr_d;
      rd_cell_q     <= rd_cell_d;
    end
  end

  // Line buffer storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      line_mem_q[wr_addr] <= mem_readdata_i;
    end
  end

  assign mem_address_o = mem_addr_q;
  assign mem_read_o    = mem_read_q;
  assign rd_cell_o     = rd_cell_q;
  assign line_ready_o  = line_ready_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Bench for vga_line_fetcher: Avalon slave with programmable latency/stall, a
// row-level reference model checked every cycle, and directed literal checks.
module tb_vga_line_fetcher;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = '0;
  logic        mem_readdatavalid = 1'b0;
  logic [23:0] frame_base = 24'h000100;
  logic        line_req = 1'b0;
  logic [7:0]  line_row = '0;
  logic [7:0]  rd_col = '0;
  logic [1:0]  rd_cell;
  logic        line_ready;
  logic        underrun;

  vga_line_fetcher dut (
    .clock               (clock),
    .reset               (reset),
    .mem_address_o       (mem_address),
    .mem_read_o          (mem_read),
    .mem_waitrequest_i   (mem_waitrequest),
    .mem_readdata_i      (mem_readdata),
    .mem_readdatavalid_i (mem_readdatavalid),
    .frame_base_i        (frame_base),
    .line_req_i          (line_req),
    .line_row_i          (line_row),
    .rd_col_i            (rd_col),
    .rd_cell_o           (rd_cell),
    .line_ready_o        (line_ready),
    .underrun_o          (underrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SDRAM image: explicit words override a fixed address-derived pattern.
  logic [31:0] mem_img [int];

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    if (mem_img.exists(int'(a))) return mem_img[int'(a)];
    return {~a[15:0], a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [1:0] cell_of(input logic [23:0] fb, input logic [7:0] col);
    logic [31:0] w;
    w = mem_word(fb + 24'(col / 8'd16)) >> (2 * int'(col % 8'd16));
    return w[1:0];
  endfunction

  // Slave: accepts sampled mid-cycle, data returned in order after 'latency' cycles.
  typedef struct {
    logic [23:0] addr;
    int          due;
  } rd_t;

  rd_t         sq[$];
  rd_t         r;
  logic [23:0] acc_log[$];
  int          cyc = 0;
  int          latency = 3;
  int          ret_cnt = 0;
  int          acc_cnt = 0;
  logic [23:0] stall_addr = '0;
  int          stall_left = 0;

  always begin
    @(negedge clock);
    if (!reset && mem_read && !mem_waitrequest) begin
      sq.push_back('{mem_address, cyc + latency});
      acc_log.push_back(mem_address);
      acc_cnt++;
    end
    @(posedge clock);
    #1;
    cyc++;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    if (sq.size() > 0 && sq[0].due <= cyc) begin
      r = sq.pop_front();
      mem_readdatavalid = 1'b1;
      mem_readdata      = mem_word(r.addr);
      ret_cnt++;
    end
    if (stall_left > 0 && mem_read && mem_address == stall_addr) begin
      mem_waitrequest = 1'b1;
      stall_left--;
    end else begin
      mem_waitrequest = 1'b0;
    end
  end

  // Reference model: tracks requests by tag, not by FSM state.
  bit          m_busy, m_ready, m_fv, m_und;
  logic [23:0] m_base, m_fbase, m_dbase;
  int          m_issued, m_returned, m_id;
  int          tags[$];
  logic [1:0]  m_rd;
  bit          prev_stall;
  logic [23:0] prev_addr;
  int          max_out = 0;
  int          und_cnt = 0;
  bit          was_busy, done, old_out;
  int          t;

  always @(negedge clock) begin
    if (reset) begin
      check("reset_mem_read", mem_read, 0);
      check("reset_mem_address", mem_address, 0);
      check("reset_rd_cell", rd_cell, 0);
      check("reset_line_ready", line_ready, 0);
      check("reset_underrun", underrun, 0);
      m_busy = 0; m_ready = 0; m_fv = 0; m_und = 0; m_rd = '0;
      m_issued = 0; m_returned = 0;
      tags.delete();
      prev_stall = 0;
    end else begin
      check("line_ready", line_ready, m_ready);
      check("underrun", underrun, m_und);
      check("rd_cell", rd_cell, m_rd);
      if (prev_stall) begin
        check("hold_read", mem_read, 1);
        check("hold_addr", mem_address, prev_addr);
      end
      old_out = 0;
      foreach (tags[i]) if (tags[i] != m_id) old_out = 1;
      if (old_out) check("drain_no_read", mem_read, 0);
      if (underrun) und_cnt++;
      was_busy = m_busy;
      if (mem_read && !mem_waitrequest) begin
        check("issue_addr", mem_address, m_base + 24'(m_issued));
        check("issue_limit", 32'(tags.size() < 4 && m_issued < 10), 1);
        tags.push_back(m_id);
        m_issued++;
        if (tags.size() > max_out) max_out = tags.size();
      end
      done = 0;
      if (mem_readdatavalid && tags.size() > 0) begin
        t = tags.pop_front();
        if (t == m_id && m_busy) begin
          m_returned++;
          if (m_returned == 10) done = 1;
        end
      end
      m_rd  = (m_fv && rd_col < 8'd160) ? cell_of(m_fbase, rd_col) : 2'b00;
      m_und = 0;
      if (line_req) begin
        if (was_busy) begin
          m_und = 1;
          m_fv  = 0;
        end else begin
          m_fv    = m_ready;
          m_fbase = m_dbase;
          m_ready = 0;
        end
        m_busy = 1;
        m_id++;
        m_base     = frame_base + 24'(line_row) * 24'd10;
        m_issued   = 0;
        m_returned = 0;
      end else if (done) begin
        m_ready = 1;
        m_dbase = m_base;
        m_busy  = 0;
      end
      prev_stall = mem_read && mem_waitrequest && !line_req;
      prev_addr  = mem_address;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_req(input logic [7:0] row);
    line_row = row;
    line_req = 1'b1;
    step();
    line_req = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    while (!line_ready && n < budget) begin
      step();
      n++;
    end
    check(name, line_ready, 1);
  endtask

  task automatic sweep();
    for (int c = 0; c < 160; c++) begin
      rd_col = 8'(c);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int n, r0, a0, bad;
    mem_img[32'h114] = 32'h0000_00E4;   // row 2 word 0 -> cells 0,1,2,3
    mem_img[32'h163] = 32'hC000_0001;   // row 9 word 9 -> cell 144 = 1, cell 159 = 3
    repeat (3) step();
    reset = 1'b0;
    step();
    check("t0_mem_read", mem_read, 0);
    check("t0_line_ready", line_ready, 0);

    // Zero-wait, latency 3, row 2 from base 0x100
    acc_log.delete();
    pulse_req(8'd2);
    wait_ready("t1_ready", 60);
    check("t1_count", acc_log.size(), 10);
    for (int i = 0; i < acc_log.size() && i < 10; i++) check("t1_addr", acc_log[i], 24'h114 + i);

    // Row 5 (base 0x132) with a 5-cycle stall on word 3; front now shows row 2
    stall_addr = 24'h000135;
    stall_left = 5;
    pulse_req(8'd5);
    n = 0;
    while (!mem_waitrequest && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("t3_wait", mem_waitrequest, 1);
      check("t3_read", mem_read, 1);
      check("t3_addr", mem_address, 24'h000135);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      rd_col = 8'(c);
      step();
      check("t2_cell", rd_cell, c);
    end
    wait_ready("t3_ready", 80);
    check("t3_max_out", 32'(max_out <= 4), 1);

    // Abort row 7 after 6 returns, restart with row 9
    latency = 6;
    r0 = ret_cnt;
    pulse_req(8'd7);
    n = 0;
    while (ret_cnt - r0 < 6 && n < 100) begin
      step();
      n++;
    end
    check("t4_six_returns", ret_cnt - r0, 6);
    pulse_req(8'd9);
    bad = 0;
    for (int c = 0; c < 160; c++) begin
      rd_col = 8'(c);
      step();
      if (rd_cell != 2'b00) bad++;
    end
    check("t4_zero_cells", bad, 0);
    check("t4_underrun_count", und_cnt, 1);
    wait_ready("t4_ready", 300);

    // Swap row 9 to the front; column edge cases
    latency = 3;
    pulse_req(8'd0);
    rd_col = 8'd159; step(); check("t5_col159", rd_cell, 3);
    rd_col = 8'd160; step(); check("t5_col160", rd_cell, 0);
    rd_col = 8'd255; step(); check("t5_col255", rd_cell, 0);
    rd_col = 8'd144; step(); check("t5_col144", rd_cell, 1);
    sweep();
    wait_ready("t5_ready", 60);

    // Reset with 3 reads outstanding, then stray returns
    latency = 8;
    a0 = acc_cnt;
    pulse_req(8'd1);
    n = 0;
    while (acc_cnt - a0 < 3 && n < 50) begin
      step();
      n++;
    end
    check("t6_three_out", acc_cnt - a0, 3);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n = 0;
    while (sq.size() > 0 && n < 30) begin
      step();
      n++;
    end
    step();
    check("t6_line_ready", line_ready, 0);
    check("t6_mem_read", mem_read, 0);
    check("t6_mem_address", mem_address, 0);
    check("t6_underrun", underrun, 0);
    check("t6_rd_cell", rd_cell, 0);
    latency = 3;
    pulse_req(8'd3);
    wait_ready("t6_fresh_ready", 60);
    pulse_req(8'd4);
    sweep();
    wait_ready("t6_row4_ready", 60);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
